vpu_scanout: RTL and testbench

- Consumer end of the VPU colour stream. Captures the merged per-pixel colour from the BG/sprite compositor into a ping-pong line buffer, one line at a time.
- Replays the buffer with free-running display timing: dot-rate enable, hsync, vsync and data-enable.
- Sits between the VPU renderer and the board video encoder (VGA/HDMI TX).
- Decouples render timing from display timing by one full line.

---
 rtl/gameconsole_pkg.sv | 30 +++
 rtl/vpu_scanout_linebuf.sv | 25 ++
 rtl/vpu_scanout.sv | 175 +++++++++++++++++
 tb/tb_vpu_scanout.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gameconsole_pkg.sv
// Shared constants and types for the VPU scanout path: screen geometry,
// display timing and the linebuffer address layout.
package gameconsole_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam int VO_H_TOTAL  = 400;
    localparam int VO_V_TOTAL  = 262;
    localparam int VO_HS_START = 328;
    localparam int VO_HS_LEN   = 32;
    localparam int VO_VS_START = 244;
    localparam int VO_VS_LEN   = 3;
    localparam int VO_DOT_DIV  = 4;

    localparam int X_W    = $clog2(SCREEN_W);
    localparam int H_W    = $clog2(VO_H_TOTAL);
    localparam int V_W    = $clog2(VO_V_TOTAL);
    localparam int DCNT_W = $clog2(VO_DOT_DIV);

    // Address is {bank, x}, so one bank bit on top of the pixel index.
    localparam int LINEBUF_ADDR_W = $clog2(2 * SCREEN_W);

    typedef struct packed {
        logic overflow;
        logic underrun;
        logic short_line;
    } err_t;

endpackage

// File: rtl/vpu_scanout_linebuf.sv
// Ping-pong line storage: one write port, one registered read port.
// Depth covers the full {bank, x} address space, so bank 1 starts at 512.
module vpu_linebuf_dp
    import gameconsole_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [LINEBUF_ADDR_W-1:0] waddr,
    input  logic [23:0]               wdata,
    input  logic                      re,
    input  logic [LINEBUF_ADDR_W-1:0] raddr,
    output logic [23:0]               rd_data
);

    logic [23:0] mem [2**LINEBUF_ADDR_W];
    logic [23:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_data_q <= mem[raddr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vpu_scanout.sv
// Captures rendered lines into a ping-pong buffer and replays them with
// free-running display timing, one line behind the renderer.
module vpu_scanout
    import gameconsole_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_line_start,
    input  logic        in_valid,
    input  logic [31:0] in_color,
    input  logic        err_clear,
    output logic        vo_dot_en,
    output logic [23:0] vo_rgb,
    output logic        vo_de,
    output logic        vo_hs,
    output logic        vo_vs,
    output logic        err_overflow,
    output logic        err_underrun,
    output logic        err_short_line
);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(VO_DOT_DIV - 1);
    localparam logic [H_W-1:0] H_LAST  = H_W'(VO_H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT   = H_W'(SCREEN_W);
    localparam logic [H_W-1:0] H_ALAST = H_W'(SCREEN_W - 1);
    localparam logic [H_W-1:0] HS_BEG  = H_W'(VO_HS_START);
    localparam logic [H_W-1:0] HS_END  = H_W'(VO_HS_START + VO_HS_LEN);
    localparam logic [V_W-1:0] V_LAST  = V_W'(VO_V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT   = V_W'(SCREEN_H);
    localparam logic [V_W-1:0] VS_BEG  = V_W'(VO_VS_START);
    localparam logic [V_W-1:0] VS_END  = V_W'(VO_VS_START + VO_VS_LEN);
    localparam logic [X_W-1:0] X_LAST  = X_W'(SCREEN_W - 1);

    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [X_W-1:0]    wr_x_q, wr_x_d, wr_x_eff;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]        line_ready_q, line_ready_d, ready_set, ready_clr;
    logic              line_act_q, line_act_d;
    err_t              err_q, err_d;
    logic [23:0]       vo_rgb_q, vo_rgb_d;
    logic              vo_de_q, vo_de_d, vo_hs_q, vo_hs_d, vo_vs_q, vo_vs_d;

    logic        dot_en, wr_en, rd_en, line_start_dot, line_end_dot, de_now, act_now;
    logic [23:0] rd_data;
    logic        unused_alpha;

    assign unused_alpha = ^in_color[31:24];

    vpu_linebuf_dp u_linebuf (
        .clk     (clk),
        .we      (wr_en),
        .waddr   ({wr_bank_q, wr_x_eff}),
        .wdata   (in_color[23:0]),
        .re      (rd_en),
        .raddr   ({rd_bank_q, h_q[X_W-1:0]}),
        .rd_data (rd_data)
    );

    always_comb begin
        dot_en = (dcnt_q == DCNT_LAST);
        rd_en  = (dcnt_q == '0);
        dcnt_d = dot_en ? '0 : dcnt_q + DCNT_W'(1);
        h_d    = h_q;
        v_d    = v_q;
        if (dot_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
            end else begin
                h_d = h_q + H_W'(1);
            end
        end
    end

    // Write side; a dropped pixel still advances x so line framing is kept.
    always_comb begin
        wr_x_eff  = in_line_start ? '0 : wr_x_q;
        wr_en     = in_valid && !line_ready_q[wr_bank_q];
        wr_x_d    = wr_x_eff;
        wr_bank_d = wr_bank_q;
        ready_set = '0;
        if (in_valid) begin
            if (wr_x_eff == X_LAST) begin
                ready_set[wr_bank_q] = 1'b1;
                wr_bank_d            = ~wr_bank_q;
                wr_x_d               = '0;
            end else begin
                wr_x_d = wr_x_eff + X_W'(1);
            end
        end
    end

    // Read side holds the bank ready until its last active dot is shown.
    always_comb begin
        line_start_dot = dot_en && (h_q == '0) && (v_q < V_ACT);
        line_end_dot   = dot_en && (h_q == H_ALAST) && line_act_q;
        line_act_d     = line_act_q;
        ready_clr      = '0;
        rd_bank_d      = rd_bank_q;
        if (line_start_dot) line_act_d = line_ready_q[rd_bank_q];
        if (line_end_dot) begin
            line_act_d           = 1'b0;
            ready_clr[rd_bank_q] = 1'b1;
            rd_bank_d            = ~rd_bank_q;
        end
        line_ready_d = (line_ready_q & ~ready_clr) | ready_set;
    end

    always_comb begin
        err_d = err_clear ? '0 : err_q;
        if (in_valid && line_ready_q[wr_bank_q])               err_d.overflow   = 1'b1;
        if (line_start_dot && !line_ready_q[rd_bank_q])        err_d.underrun   = 1'b1;
        if (in_line_start && (wr_x_q != '0))                   err_d.short_line = 1'b1;
    end

    // At h==0 line_act is being latched this dot, so use its incoming value.
    always_comb begin
        de_now   = (h_q < H_ACT) && (v_q < V_ACT);
        act_now  = (h_q == '0) ? line_ready_q[rd_bank_q] : line_act_q;
        vo_rgb_d = vo_rgb_q;
        vo_de_d  = vo_de_q;
        vo_hs_d  = vo_hs_q;
        vo_vs_d  = vo_vs_q;
        if (dot_en) begin
            vo_rgb_d = (de_now && act_now) ? rd_data : '0;
            vo_de_d  = de_now;
            vo_hs_d  = (h_q >= HS_BEG) && (h_q < HS_END);
            vo_vs_d  = (v_q >= VS_BEG) && (v_q < VS_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q       <= '0;
            h_q          <= '0;
            v_q          <= '0;
            wr_x_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            line_ready_q <= '0;
            line_act_q   <= 1'b0;
            err_q        <= '0;
            vo_rgb_q     <= '0;
            vo_de_q      <= 1'b0;
            vo_hs_q      <= 1'b0;
            vo_vs_q      <= 1'b0;
        end else begin
            dcnt_q       <= dcnt_d;
            h_q          <= h_d;
            v_q          <= v_d;
            wr_x_q       <= wr_x_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            line_ready_q <= line_ready_d;
            line_act_q   <= line_act_d;
            err_q        <= err_d;
            vo_rgb_q     <= vo_rgb_d;
            vo_de_q      <= vo_de_d;
            vo_hs_q      <= vo_hs_d;
            vo_vs_q      <= vo_vs_d;
        end
    end

    assign vo_dot_en      = dot_en;
    assign vo_rgb         = vo_rgb_q;
    assign vo_de          = vo_de_q;
    assign vo_hs          = vo_hs_q;
    assign vo_vs          = vo_vs_q;
    assign err_overflow   = err_q.overflow;
    assign err_underrun   = err_q.underrun;
    assign err_short_line = err_q.short_line;

endmodule

// File: tb/tb_vpu_scanout.sv
// Directed bench for vpu_scanout: a dot-accurate timing model plus a queue of
// expected pixels, checked on every dot of the lines under observation.
module tb_vpu_scanout;

    localparam int W = 320, H = 240, HT = 400, VT = 262;
    localparam int HS0 = 328, HSL = 32, VS0 = 244, VSL = 3, DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_line_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_color = '0;
    logic        err_clear = 1'b0;
    logic        vo_dot_en, vo_de, vo_hs, vo_vs;
    logic [23:0] vo_rgb;
    logic        err_overflow, err_underrun, err_short_line;

    int          total = 0;
    int          bad = 0;
    int          th, tv, de_cnt;
    bit          first_dot;
    bit          show_line [VT];
    logic [23:0] exp_q [$];

    vpu_scanout dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_line_start  (in_line_start),
        .in_valid       (in_valid),
        .in_color       (in_color),
        .err_clear      (err_clear),
        .vo_dot_en      (vo_dot_en),
        .vo_rgb         (vo_rgb),
        .vo_de          (vo_de),
        .vo_hs          (vo_hs),
        .vo_vs          (vo_vs),
        .err_overflow   (err_overflow),
        .err_underrun   (err_underrun),
        .err_short_line (err_short_line)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_errs(input string tag, input bit o, input bit u, input bit s);
        chk({tag, "_overflow"},   32'(err_overflow),   32'(o));
        chk({tag, "_underrun"},   32'(err_underrun),   32'(u));
        chk({tag, "_short_line"}, 32'(err_short_line), 32'(s));
    endtask

    // Assert reset for 3 cycles, check outputs clear immediately, then
    // release on a falling edge and restart the bench timing model.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_rgb"},    32'(vo_rgb),    32'h0);
        chk({tag, "_rst_de"},     32'(vo_de),     32'h0);
        chk({tag, "_rst_hs"},     32'(vo_hs),     32'h0);
        chk({tag, "_rst_vs"},     32'(vo_vs),     32'h0);
        chk({tag, "_rst_dot_en"}, 32'(vo_dot_en), 32'h0);
        chk_errs({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        th        = 0;
        tv        = 0;
        de_cnt    = 0;
        first_dot = 1'b1;
        exp_q.delete();
        for (int i = 0; i < VT; i++) show_line[i] = 1'b0;
    endtask

    task automatic feed_line(input int n, input bit start, input bit push, input bit ramp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid      = 1'b1;
            in_line_start = start && (i == 0);
            in_color      = ramp ? 32'h8000_0000 + 32'(i) : 32'($urandom);
            if (push) exp_q.push_back(in_color[23:0]);
        end
        @(negedge clk);
        in_valid      = 1'b0;
        in_line_start = 1'b0;
        in_color      = '0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Outputs for dot (th,tv) are registered on its dot_en edge.
    task automatic run_dots(input int n);
        for (int i = 0; i < n; i++) begin
            int          k;
            bit          exp_de, exp_hs, exp_vs;
            logic [23:0] exp_rgb;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!vo_dot_en && k < 8);
            if (first_dot) chk("first_dot_latency", 32'(k), 32'd3);
            else           chk("dot_period", 32'(k), 32'(DIV));
            first_dot = 1'b0;
            @(posedge clk);
            #1;
            exp_de  = (th < W) && (tv < H);
            exp_hs  = (th >= HS0) && (th < HS0 + HSL);
            exp_vs  = (tv >= VS0) && (tv < VS0 + VSL);
            exp_rgb = '0;
            if (exp_de && show_line[tv]) begin
                chk("exp_q_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) exp_rgb = exp_q.pop_front();
            end
            chk("rgb", 32'(vo_rgb), 32'(exp_rgb));
            chk("de", 32'(vo_de), 32'(exp_de));
            chk("hs", 32'(vo_hs), 32'(exp_hs));
            chk("vs", 32'(vo_vs), 32'(exp_vs));
            chk("dot_en_single", 32'(vo_dot_en), 32'h0);
            if (exp_de) de_cnt++;
            if (th == HT - 1) begin
                if (tv < H) chk("de_per_line", 32'(de_cnt), 32'(W));
                de_cnt = 0;
                th     = 0;
                tv     = (tv == VT - 1) ? 0 : tv + 1;
            end else begin
                th++;
            end
        end
    endtask

    initial begin
        // Ramp line written during line 0 appears on line 1; line 2 underruns.
        do_reset("por");
        show_line[1] = 1'b1;
        fork
            begin
                feed_line(W, 1'b1, 1'b1, 1'b1);
                repeat (3000 - (W + 1)) @(negedge clk);
                chk_errs("s1_pre_clear", 1'b0, 1'b1, 1'b0);
                pulse_clear();
                chk_errs("s1_cleared", 1'b0, 1'b0, 1'b0);
            end
            run_dots(3 * HT + 100);
        join
        chk_errs("s1_line2_underrun", 1'b0, 1'b1, 1'b0);
        chk("s1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Mid-frame reset (line 3, h~100), then three lines back to back.
        do_reset("mid");
        show_line[1] = 1'b1;
        show_line[2] = 1'b1;
        fork
            begin
                feed_line(W, 1'b1, 1'b1, 1'b0);
                feed_line(W, 1'b1, 1'b1, 1'b0);
                feed_line(W, 1'b1, 1'b0, 1'b0);
                chk_errs("s2_overflow", 1'b1, 1'b1, 1'b0);
            end
            run_dots(3 * HT);
        join
        chk("s2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Partial line abandoned by a line start that coincides with pixel 0.
        do_reset("s3");
        show_line[1] = 1'b1;
        fork
            begin
                feed_line(100, 1'b1, 1'b0, 1'b0);
                feed_line(W, 1'b1, 1'b1, 1'b0);
                chk_errs("s3_short", 1'b0, 1'b1, 1'b1);
                pulse_clear();
                chk_errs("s3_cleared", 1'b0, 1'b0, 1'b0);
            end
            run_dots(2 * HT);
        join
        chk_errs("s3_no_new_err", 1'b0, 1'b0, 1'b0);
        chk("s3_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
